// File: rtl/recip_arbiter.sv
// recip_arbiter: round-robin sharing of one pipelined reciprocal datapath among
// NREQ requesters. A tag pipeline tracks each issued operand so results are
// steered back to a per-requester holding register.
// Optional feature macro: RECIP_DIVZERO_EN (zero operands return 0x7FFFFFFF with rsp_dz set).
`timescale 1ns/1ps
module recip_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*32-1:0]   rsp_data,
    output logic [NREQ-1:0]      rsp_dz,
    output logic                 dp_valid_in,
    output logic [31:0]          dp_x,
    input  logic                 dp_valid_out,
    input  logic [31:0]          dp_y,
    output logic [3:0]           outstanding,
    output logic                 orphan_err
);
    localparam int unsigned DW = 32;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned OW = 4;
    localparam logic [DW-1:0] SAT_VAL = 32'h7FFF_FFFF;
`ifdef RECIP_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
        logic          dz;
    } tag_t;

    logic [NREQ-1:0]     busy;
    logic [IW-1:0]       ptr;
    logic [NREQ-1:0]     elig;
    logic [NREQ-1:0]     grant;
    logic                gnt_any;
    logic [IW-1:0]       gnt_idx;
    logic [IW-1:0]       cand;
    logic [DW-1:0]       gnt_data;
    tag_t                iss_tag;
    tag_t [LAT-1:0]      tag_q;
    tag_t                tag_last;
    logic [NREQ-1:0]     rsp_hs;
    logic                cap;
    logic [DW-1:0]       cap_data;
    logic [OW-1:0]       out_nxt;
    int                  out_sum;

    assign elig      = req_valid & ~busy;
    assign req_ready = grant & {NREQ{rst_n}};
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign tag_last  = tag_q[LAT-1];
    assign cap       = dp_valid_out & tag_last.vld;
    assign cap_data  = tag_last.dz ? SAT_VAL : dp_y;
    assign dp_valid_in = iss_tag.vld;

    // Round-robin pick: pointer first, then increasing index modulo NREQ
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        grant    = '0;
        gnt_data = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = IW'((32'(ptr) + off) % NREQ);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_any && (gnt_idx == IW'(i))) begin
                grant[i] = 1'b1;
                gnt_data = req_data[i*DW +: DW];
            end
        end
    end

    // Saturating outstanding count: +1 per grant, -1 per response handshake
    always_comb begin
        out_sum = int'(outstanding) + (gnt_any ? 1 : 0) - int'($countones(rsp_hs));
        out_nxt = '0;
        if (out_sum > int'(NREQ)) begin
            out_nxt = OW'(NREQ);
        end else if (out_sum > 0) begin
            out_nxt = OW'(out_sum);
        end
    end

    // Busy bits, arbitration pointer and outstanding counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            ptr         <= '0;
            outstanding <= '0;
        end else begin
            busy        <= (busy | grant) & ~rsp_hs;
            outstanding <= out_nxt;
            if (gnt_any) begin
                ptr <= IW'((32'(gnt_idx) + 1) % NREQ);
            end
        end
    end

    // Registered issue stage; dp_x holds its last operand when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_tag <= '0;
            dp_x    <= '0;
        end else begin
            iss_tag.vld <= gnt_any;
            if (gnt_any) begin
                iss_tag.idx <= gnt_idx;
                iss_tag.dz  <= DZ_EN && (gnt_data == '0);
                dp_x        <= gnt_data;
            end
        end
    end

    // Tag pipeline aligned so its last stage coincides with dp_valid_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= iss_tag;
            for (int unsigned s = 1; s < LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // Per-requester result holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_dz    <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (cap && (tag_last.idx == IW'(i))) begin
                    rsp_valid[i]         <= 1'b1;
                    rsp_data[i*DW +: DW] <= cap_data;
                    rsp_dz[i]            <= tag_last.dz;
                end else if (rsp_hs[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky error for a datapath result with no matching tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orphan_err <= 1'b0;
        end else if (dp_valid_out && !tag_last.vld) begin
            orphan_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_recip_arbiter.sv
// tb_recip_arbiter: scoreboard bench for recip_arbiter with a behavioural
// reciprocal datapath model of latency LAT.
`timescale 1ns/1ps
module tb_recip_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 6;

    typedef struct packed {
        logic [31:0] data;
        logic        dz;
        int          gcyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_data;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [NREQ*32-1:0]  rsp_data;
    logic [NREQ-1:0]     rsp_dz;
    logic                dp_valid_in;
    logic [31:0]         dp_x;
    logic                dp_valid_out;
    logic [31:0]         dp_y;
    logic [3:0]          outstanding;
    logic                orphan_err;
    logic                inject;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] send_q [NREQ][$];
    exp_t        exp_q  [NREQ][$];
    logic [NREQ-1:0] hs_req;
    logic [NREQ-1:0] tb_busy;
    logic [NREQ-1:0] prev_rv;
    int          tb_ptr;
    int          out_cnt;
    int          peak_out;
    int          gcount [NREQ];
    logic        exp_dpv;
    logic [31:0] exp_dpx;
    logic        exp_orph;
    bit          drv_prev_rst;

    logic [31:0] ops [6] = '{32'h0002_0000, 32'h0004_0000, 32'h0000_8000,
                             32'h0001_0000, 32'hFFFE_0000, 32'h0003_0000};

    recip_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
        .dp_valid_in(dp_valid_in), .dp_x(dp_x), .dp_valid_out(dp_valid_out), .dp_y(dp_y),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: 2^32 / x, marker value for zero
    function automatic logic [31:0] dp_model(input logic [31:0] x);
        longint q;
        if (x == 32'h0) return 32'hDEAD_0000;
        q = 64'sh1_0000_0000 / longint'(signed'(x));
        return q[31:0];
    endfunction

    logic [LAT-1:0]        pv;
    logic [LAT-1:0][31:0]  py;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            py <= '0;
        end else begin
            pv <= {pv[LAT-2:0], dp_valid_in};
            py <= {py[LAT-2:0], dp_model(dp_x)};
        end
    end
    assign dp_valid_out = pv[LAT-1] | inject;
    assign dp_y         = py[LAT-1];

    // Hand-computed Q16.16 reciprocals
    function automatic logic [31:0] exp_of(input logic [31:0] x);
        case (x)
            32'h0002_0000: return 32'h0000_8000;
            32'h0004_0000: return 32'h0000_4000;
            32'h0000_8000: return 32'h0002_0000;
            32'h0001_0000: return 32'h0001_0000;
            32'hFFFE_0000: return 32'hFFFF_8000;
            32'h0003_0000: return 32'h0000_5555;
`ifdef RECIP_DIVZERO_EN
            32'h0000_0000: return 32'h7FFF_FFFF;
`else
            32'h0000_0000: return 32'hDEAD_0000;
`endif
            default:       return 32'hBAD0_BAD0;
        endcase
    endfunction

    function automatic logic dz_of(input logic [31:0] x);
`ifdef RECIP_DIVZERO_EN
        return (x == 32'h0);
`else
        return (x == 32'h0) && 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NREQ; i++)
            if (send_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor step: reference arbitration, issue, count and response checks
    task automatic mon_step();
        logic [NREQ-1:0] elig, exp_rdy;
        logic [31:0]     x;
        int              g, dec, c;
        exp_t            e;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_data", 32'(|rsp_data), 0);
            check("rst_rsp_dz", 32'(rsp_dz), 0);
            check("rst_dp_valid_in", 32'(dp_valid_in), 0);
            check("rst_dp_x", dp_x, 0);
            check("rst_outstanding", 32'(outstanding), 0);
            check("rst_orphan_err", 32'(orphan_err), 0);
            tb_busy = '0; tb_ptr = 0; out_cnt = 0; exp_dpv = 1'b0; exp_dpx = '0;
            exp_orph = 1'b0; prev_rv = '0; hs_req = '0;
            for (int i = 0; i < NREQ; i++) exp_q[i].delete();
            return;
        end
        elig = req_valid & ~tb_busy;
        exp_rdy = '0;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            c = (tb_ptr + k) % NREQ;
            if (g < 0 && elig[c]) begin
                g = c;
                exp_rdy[c] = 1'b1;
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("outstanding", 32'(outstanding), 32'(out_cnt));
        check("dp_valid_in", 32'(dp_valid_in), 32'(exp_dpv));
        check("dp_x", dp_x, exp_dpx);
        check("orphan_err", 32'(orphan_err), 32'(exp_orph));
        dec = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    check("unexpected_rsp_valid", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[i][0];
                    if (!prev_rv[i]) check("rsp_latency", 32'(cyc - e.gcyc), LAT + 2);
                    check("rsp_data", rsp_data[i*32 +: 32], e.data);
                    check("rsp_dz", 32'(rsp_dz[i]), 32'(e.dz));
                    if (rsp_ready[i]) begin
                        void'(exp_q[i].pop_front());
                        tb_busy[i] = 1'b0;
                        dec++;
                    end
                end
            end
        end
        prev_rv = rsp_valid & ~rsp_ready;
        if (g >= 0) begin
            x = req_data[g*32 +: 32];
            e.data = exp_of(x);
            e.dz   = dz_of(x);
            e.gcyc = cyc;
            exp_q[g].push_back(e);
            tb_busy[g] = 1'b1;
            tb_ptr  = (g + 1) % NREQ;
            exp_dpv = 1'b1;
            exp_dpx = x;
        end else begin
            exp_dpv = 1'b0;
        end
        out_cnt = out_cnt + ((g >= 0) ? 1 : 0) - dec;
        hs_req = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++) if (hs_req[i]) gcount[i]++;
        if (int'(outstanding) > peak_out) peak_out = int'(outstanding);
        if (inject) exp_orph = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_step();
        end
    end

    // Driver: presents queued operands, pops on handshake, flushes on reset entry
    initial begin : driver
        req_valid = '0;
        req_data  = '0;
        drv_prev_rst = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (drv_prev_rst && !rst_n) begin
                for (int i = 0; i < NREQ; i++) send_q[i].delete();
            end else begin
                for (int i = 0; i < NREQ; i++)
                    if (hs_req[i] && send_q[i].size() > 0) void'(send_q[i].pop_front());
            end
            drv_prev_rst = rst_n;
            for (int i = 0; i < NREQ; i++) begin
                if (send_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*32 +: 32] = send_q[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*32 +: 32] = '0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!all_idle() && n < 400) begin
            tick(1);
            n++;
        end
        check(name, 32'(all_idle()), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] one_hot;
        int g0, g1, g2, g3, n;
        rsp_ready = '1;
        inject    = 1'b0;
        peak_out  = 0;
        for (int i = 0; i < NREQ; i++) gcount[i] = 0;

        // Full load: every requester valid from reset
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 3; j++) send_q[i].push_back(ops[(i + j) % 6]);
        tick(3);
        rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            @(negedge clk);
            one_hot = 32'(1) << k;
            check("grant_order", 32'(req_ready), one_hot);
        end
        wait_idle("full_load_drain");
        check("outstanding_peak", 32'(peak_out), 4);

        // Backpressure on requester 2 for 20 cycles
        tick(1);
        rsp_ready = 4'b1011;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 4; j++) send_q[i].push_back(ops[(i * 2 + j) % 6]);
        tick(10);
        g0 = gcount[0]; g1 = gcount[1]; g2 = gcount[2]; g3 = gcount[3];
        tick(10);
        check("bp_rsp_valid2_held", 32'(rsp_valid[2]), 1);
        check("bp_no_grant_r2", 32'(gcount[2] - g2), 0);
        check("bp_others_served", 32'((gcount[0] > g0) && (gcount[1] > g1) && (gcount[3] > g3)), 1);
        rsp_ready = '1;
        wait_idle("bp_drain");

        // Single request on requester 0: 2.0 -> 0.5
        tick(2);
        send_q[0].push_back(32'h0002_0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[0] && n < 20);
        check("single_grant_seen", 32'(req_ready[0]), 1);
        @(negedge clk);
        check("single_dp_valid_in", 32'(dp_valid_in), 1);
        check("single_dp_x", dp_x, 32'h0002_0000);
        wait_idle("single_drain");

        // Zero operand and negative operand
        tick(2);
        send_q[1].push_back(32'h0000_0000);
        send_q[2].push_back(32'hFFFE_0000);
        send_q[3].push_back(32'h0003_0000);
        wait_idle("zero_drain");

        // Reset with three requests in flight
        tick(2);
        send_q[0].push_back(32'h0001_0000);
        send_q[1].push_back(32'h0004_0000);
        send_q[3].push_back(32'h0000_8000);
        tick(4);
        check("pre_reset_outstanding", 32'(outstanding), 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_req_ready", 32'(req_ready), 0);
        check("async_rst_dp_valid_in", 32'(dp_valid_in), 0);
        check("async_rst_dp_x", dp_x, 0);
        check("async_rst_outstanding", 32'(outstanding), 0);
        check("async_rst_rsp_valid", 32'(rsp_valid), 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("post_reset_no_rsp", 32'(rsp_valid), 0);
        check("post_reset_orphan", 32'(orphan_err), 0);

        // Orphan result with an empty tag pipeline
        tick(2);
        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        tick(5);
        check("orphan_sticky", 32'(orphan_err), 1);
        check("orphan_no_rsp", 32'(rsp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
